da_rom_loader: RTL and testbench
================================

// Module: da_rom_loader
// PURPOSE
//  Load sequencer and port arbiter for the DA FIR partial-sum ROM. Takes the precomputed
//  ROM words as a valid/ready stream and writes them to consecutive bank/address slots.
//  Raises rom_ready once the whole ROM is written, then hands the single ROM port to the
//  DA core. Passes core start requests through only while the ROM is loaded and the core
//  is idle. Sits between the input interface and da_control / DA ROM in the top level.
// PARAMETERS
//  DATA_W     16  ROM word width (precomputed partial sum)
//  ADDR_W     4   address bits per bank (2^ADDR_W entries = one 4-tap group)
//  NUM_BANKS  2   number of ROM banks; TOTAL = NUM_BANKS * 2^ADDR_W words
// PORTS
//  clk          in   1                  rising-edge clock
//  reset        in   1                  synchronous, active-high reset
//  din          in   DATA_W             ROM word stream
//  valid_in     in   1                  din valid
//  ready_out    out  1                  loader accepts din this cycle
//  reload       in   1                  pulse: discard loaded ROM, accept a new load
//  start_in     in   1                  start request from system
//  core_busy    in   1                  DA core mid-computation (from da_control)
//  core_cen_n   in   1                  core ROM chip enable, active-low
//  core_addr    in   ADDR_W+clog2(NB)   core ROM read address {bank,addr}
//  start_out    out  1                  gated start to da_control
//  start_err    out  1                  1-cycle pulse: start_in rejected
//  mem_cen_n    out  1                  ROM chip enable, active-low
//  mem_wen_n    out  1                  ROM write enable, active-low
//  mem_addr     out  ADDR_W+clog2(NB)   ROM address {bank,addr}
//  mem_din      out  DATA_W             ROM write data
//  rom_ready    out  1                  all TOTAL words written
//  load_count   out  clog2(TOTAL+1)     words written since last reload/reset
// BEHAVIOUR
//  Synchronous, active-high reset; all outputs registered except ready_out and start_out:
//   state=IDLE, rom_ready=0, load_count=0, mem_cen_n=1, mem_wen_n=1, mem_addr=0,
//   mem_din=0, start_err=0, ready_out=0, start_out=0. ROM contents are not cleared.
//  FSM states:
//   IDLE   : ready_out=0. Goes to LOAD on the next cycle.
//   LOAD   : ready_out=1. A transfer happens on (valid_in & ready_out) at edge N.
//            At N+1: mem_cen_n=0, mem_wen_n=0, mem_addr=word index, mem_din=din.
//            With no transfer, cen/wen are 1 (no write). Index counts up; low ADDR_W
//            bits are the address, upper bits the bank. After the TOTAL-th transfer:
//            ready_out=0 at once, state goes to LOCKED, rom_ready=1 at N+2.
//   LOCKED : ready_out=0; mem_wen_n held 1; mem_cen_n=core_cen_n, mem_addr=core_addr,
//            both registered, 1-cycle delay.
//  Start gating: start_out = start_in & rom_ready & ~core_busy (combinational).
//   start_err pulses at the cycle after any start_in with start_out=0.
//  Reload: in LOAD or LOCKED with core_busy=0, go to IDLE next cycle. rom_ready=0 and
//   load_count=0 on that edge.
//   reload while core_busy=1: latch reload_pend. Act on the first cycle core_busy=0.
//   reload in IDLE has no effect.
//  Simultaneous: reload plus a transfer in the same cycle drops the word (not written).
//   reload plus start_in: start_in is evaluated on the old rom_ready.
//  Counter never exceeds TOTAL; valid_in in LOCKED/IDLE is ignored (ready_out=0).
//  Reset mid-load: counter restarts at 0; a partial ROM is never reported ready.
// STRUCTURE
//  Shared package da_pkg: ROM_ON=1'b0/ROM_OFF=1'b1 enable encodings, loader state
//  localparams (IDLE/LOAD/LOCKED), DATA_W/ADDR_W/NUM_BANKS defaults.
//  One sub-module: da_rom_port_mux (registered loader/core select of cen/wen/addr/din).
//  FSM, counter and start gating stay in the top module.
// TESTING
//  1 Reset, stream 32 words 0x0100..0x011F back-to-back (NB=2) -> 32 writes at addr
//    0..31 with matching data, cen/wen low 1 cycle after each accept, rom_ready=1 two
//    cycles after the 32nd accept, load_count=32.
//  2 Random valid_in gaps (50%) during load -> no write on idle cycles, still addresses
//    0..31 in order, ready_out=0 after the last word.
//  3 start_in at load_count=10 -> start_out=0, start_err pulse. start_in after rom_ready
//    with core_busy=0 -> start_out=1 in the same cycle.
//  4 LOCKED, core_cen_n=0, core_addr=5'h13 -> mem_cen_n=0, mem_addr=5'h13, mem_wen_n=1
//    one cycle later. Extra valid_in words are ignored.
//  5 reload while core_busy=1 for 6 cycles -> rom_ready stays 1 until core_busy falls,
//    then IDLE; rom_ready=0 and load_count=0 next edge; a second full load succeeds.
//  6 reset asserted after 7 words -> all outputs at reset values; a new 32-word load
//    starts at addr 0.

Source files
------------

// File: rtl/da_rom_loader_pkg.sv
// Shared definitions for the DA ROM loader: enable encodings, loader states,
// default geometry and a helper for the {bank,addr} width.
package da_rom_loader_pkg;

  localparam logic ROM_ON  = 1'b0;
  localparam logic ROM_OFF = 1'b1;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 4;
  localparam int NUM_BANKS_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LOCKED = 2'd2
  } ld_state_e;

  // Width of the flat ROM address {bank,addr}.
  function automatic int rom_addr_bits(input int addr_w, input int num_banks);
    return addr_w + $clog2(num_banks);
  endfunction

endpackage

// File: rtl/da_rom_loader_if.sv
// Bundle of the loader's stream, core-side and ROM-side signals.
interface da_rom_loader_if
  import da_rom_loader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF
);
  localparam int AW    = rom_addr_bits(ADDR_W, NUM_BANKS);
  localparam int TOTAL = NUM_BANKS * (2 ** ADDR_W);
  localparam int CW    = $clog2(TOTAL + 1);

  logic [DATA_W-1:0] din;
  logic              valid_in;
  logic              ready_out;
  logic              reload;
  logic              start_in;
  logic              core_busy;
  logic              core_cen_n;
  logic [AW-1:0]     core_addr;
  logic              start_out;
  logic              start_err;
  logic              mem_cen_n;
  logic              mem_wen_n;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              rom_ready;
  logic [CW-1:0]     load_count;

  // Loader side.
  modport slave (
    input  din, valid_in, reload, start_in, core_busy, core_cen_n, core_addr,
    output ready_out, start_out, start_err, mem_cen_n, mem_wen_n, mem_addr,
           mem_din, rom_ready, load_count
  );

  // System / core side driving the loader.
  modport master (
    output din, valid_in, reload, start_in, core_busy, core_cen_n, core_addr,
    input  ready_out, start_out, start_err, mem_cen_n, mem_wen_n, mem_addr,
           mem_din, rom_ready, load_count
  );
endinterface

// File: rtl/da_rom_loader_port_mux.sv
// Registered owner select for the single ROM port: a pending loader write wins,
// otherwise the core drives cen/addr once the ROM is locked; writes never leak
// from the core side.
module da_rom_loader_port_mux
  import da_rom_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              sel_core_i,
  input  logic              core_cen_n_i,
  input  logic [AW-1:0]     core_addr_i,
  output logic              mem_cen_n_o,
  output logic              mem_wen_n_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o
);
  logic              cen_q;
  logic              wen_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] din_q;

  // Register the selected port owner's controls; data only changes on writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cen_q  <= ROM_OFF;
      wen_q  <= ROM_OFF;
      addr_q <= '0;
      din_q  <= '0;
    end else if (wr_req_i) begin
      cen_q  <= ROM_ON;
      wen_q  <= ROM_ON;
      addr_q <= wr_addr_i;
      din_q  <= wr_data_i;
    end else if (sel_core_i) begin
      cen_q  <= core_cen_n_i;
      wen_q  <= ROM_OFF;
      addr_q <= core_addr_i;
    end else begin
      cen_q  <= ROM_OFF;
      wen_q  <= ROM_OFF;
    end
  end

  assign mem_cen_n_o = cen_q;
  assign mem_wen_n_o = wen_q;
  assign mem_addr_o  = addr_q;
  assign mem_din_o   = din_q;
endmodule

// File: rtl/da_rom_loader.sv
// DA ROM load sequencer: accepts the partial-sum stream, writes consecutive
// {bank,addr} slots, reports rom_ready when full, then hands the port to the
// core and gates start requests.
module da_rom_loader
  import da_rom_loader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  da_rom_loader_if.slave bus
);
  localparam int AW    = rom_addr_bits(ADDR_W, NUM_BANKS);
  localparam int TOTAL = NUM_BANKS * (2 ** ADDR_W);
  localparam int CW    = $clog2(TOTAL + 1);

  ld_state_e         state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rom_ready_q, rom_ready_d;
  logic              pend_q, pend_d;
  logic              wr_req_q, wr_req_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              start_err_q, start_err_d;
  logic              ready;
  logic              reload_now;
  logic              accept;
  logic              start_ok;

  // State, index, written-word counter and staged write register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      rom_ready_q <= 1'b0;
      pend_q      <= 1'b0;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rom_ready_q <= rom_ready_d;
      pend_q      <= pend_d;
      wr_req_q    <= wr_req_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      start_err_q <= start_err_d;
    end
  end

  // Next-state, handshake, reload arbitration and start gating.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    wr_req_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ready       = (state_q == ST_LOAD);
    // A reload (fresh or deferred) only takes effect while the core is idle.
    reload_now  = (bus.reload | pend_q) & ~bus.core_busy & (state_q != ST_IDLE);
    accept      = bus.valid_in & ready & ~reload_now;
    start_ok    = bus.start_in & rom_ready_q & ~bus.core_busy;
    start_err_d = bus.start_in & ~start_ok;
    // Count lags the accept by one cycle so it tracks words actually written.
    if (wr_req_q && (cnt_q != CW'(TOTAL))) cnt_d = cnt_q + CW'(1);
    rom_ready_d = (cnt_q == CW'(TOTAL));

    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
        idx_d   = '0;
        pend_d  = 1'b0;
      end
      ST_LOAD: begin
        if (accept) begin
          wr_req_d  = 1'b1;
          wr_addr_d = idx_q[AW-1:0];
          wr_data_d = bus.din;
          idx_d     = idx_q + CW'(1);
          if (idx_q == CW'(TOTAL - 1)) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: ;
      default: state_d = ST_IDLE;
    endcase

    if (reload_now) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      cnt_d       = '0;
      rom_ready_d = 1'b0;
      pend_d      = 1'b0;
    end else if (bus.reload && bus.core_busy && (state_q != ST_IDLE)) begin
      pend_d = 1'b1;
    end
  end

  da_rom_loader_port_mux #(
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_port_mux (
    .clk         (clk),
    .reset       (reset),
    .wr_req_i    (wr_req_q),
    .wr_addr_i   (wr_addr_q),
    .wr_data_i   (wr_data_q),
    .sel_core_i  (state_q == ST_LOCKED),
    .core_cen_n_i(bus.core_cen_n),
    .core_addr_i (bus.core_addr),
    .mem_cen_n_o (bus.mem_cen_n),
    .mem_wen_n_o (bus.mem_wen_n),
    .mem_addr_o  (bus.mem_addr),
    .mem_din_o   (bus.mem_din)
  );

  assign bus.ready_out  = ready;
  assign bus.start_out  = start_ok;
  assign bus.start_err  = start_err_q;
  assign bus.rom_ready  = rom_ready_q;
  assign bus.load_count = cnt_q;
endmodule

// File: tb/tb_da_rom_loader.sv
// Directed bench for da_rom_loader (DATA_W=16, ADDR_W=4, NUM_BANKS=2).
module tb_da_rom_loader;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  da_rom_loader_if #(.DATA_W(16), .ADDR_W(4), .NUM_BANKS(2)) bus ();

  da_rom_loader #(.DATA_W(16), .ADDR_W(4), .NUM_BANKS(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream words from..upto-1 (data base+i, expected address i) with gap_pct% idle
  // cycles, checking each write lands one cycle after its accept, then flush.
  task automatic load_range(input int from, input int upto, input int gap_pct,
                            input logic [15:0] base);
    int i, guard;
    bit prev, v;
    logic [4:0]  pa;
    logic [15:0] pd;
    i = from; guard = 0; prev = 1'b0; pa = '0; pd = '0;
    while (i < upto && guard < 1000) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      bus.valid_in = v;
      bus.din      = base + 16'(i);
      total++;
      if (bus.ready_out !== 1'b1) begin
        bad++; $display("FAIL load_ready idx=%0d got=%b exp=1", i, bus.ready_out);
      end
      tick();
      total++;
      if (prev) begin
        if ({bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr, bus.mem_din} !== {2'b00, pa, pd}) begin
          bad++;
          $display("FAIL load_write got cen=%b wen=%b addr=%h din=%h exp cen=0 wen=0 addr=%h din=%h",
                   bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr, bus.mem_din, pa, pd);
        end
      end else if ({bus.mem_cen_n, bus.mem_wen_n} !== 2'b11) begin
        bad++;
        $display("FAIL load_idle got cen=%b wen=%b exp cen=1 wen=1", bus.mem_cen_n, bus.mem_wen_n);
      end
      prev = v;
      if (v) begin
        pa = 5'(i);
        pd = base + 16'(i);
        i++;
      end
      guard++;
    end
    total++;
    if (guard >= 1000) begin
      bad++; $display("FAIL load_timeout got=%0d exp=%0d words", i, upto);
    end
    bus.valid_in = 1'b0;
    if (upto == 32) begin
      total++;
      if (bus.ready_out !== 1'b0) begin
        bad++; $display("FAIL ready_after_last got=%b exp=0", bus.ready_out);
      end
    end
    tick();
    total++;
    if ({bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr, bus.mem_din} !== {2'b00, pa, pd}) begin
      bad++;
      $display("FAIL last_write got cen=%b wen=%b addr=%h din=%h exp addr=%h din=%h",
               bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr, bus.mem_din, pa, pd);
    end
    total++;
    if (bus.load_count !== 6'(upto)) begin
      bad++; $display("FAIL load_count got=%0d exp=%0d", bus.load_count, upto);
    end
  endtask

  // After a full load flush: rom_ready still low, rises on the following edge.
  task automatic expect_rom_ready_rise();
    total++;
    if (bus.rom_ready !== 1'b0) begin
      bad++; $display("FAIL rom_ready_early got=%b exp=0", bus.rom_ready);
    end
    tick();
    total++;
    if (bus.rom_ready !== 1'b1) begin
      bad++; $display("FAIL rom_ready_rise got=%b exp=1", bus.rom_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.ready_out, bus.rom_ready, bus.load_count, bus.mem_cen_n, bus.mem_wen_n,
         bus.mem_addr, bus.mem_din, bus.start_err, bus.start_out} !==
        {1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 5'd0, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b rr=%b cnt=%0d cen=%b wen=%b addr=%h din=%h err=%b so=%b",
               bus.ready_out, bus.rom_ready, bus.load_count, bus.mem_cen_n, bus.mem_wen_n,
               bus.mem_addr, bus.mem_din, bus.start_err, bus.start_out);
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.ready_out !== 1'b1) begin
      bad++; $display("FAIL idle_to_load got=%b exp=1", bus.ready_out);
    end
  endtask

  task automatic test_full_load();
    load_range(0, 32, 0, 16'h0100);
    expect_rom_ready_rise();
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    total++;
    if ({bus.rom_ready, bus.load_count, bus.ready_out} !== {1'b0, 6'd0, 1'b0}) begin
      bad++;
      $display("FAIL reload_clear got rr=%b cnt=%0d rdy=%b exp 0/0/0",
               bus.rom_ready, bus.load_count, bus.ready_out);
    end
    tick();
  endtask

  task automatic test_gapped_load();
    do_reload();
    load_range(0, 32, 50, 16'h0200);
    expect_rom_ready_rise();
  endtask

  task automatic test_start_gating();
    do_reload();
    load_range(0, 10, 0, 16'h0300);
    bus.start_in = 1'b1;
    #1;
    total++;
    if (bus.start_out !== 1'b0) begin
      bad++; $display("FAIL start_blocked got=%b exp=0", bus.start_out);
    end
    tick();
    bus.start_in = 1'b0;
    total++;
    if (bus.start_err !== 1'b1) begin
      bad++; $display("FAIL start_err_pulse got=%b exp=1", bus.start_err);
    end
    tick();
    total++;
    if (bus.start_err !== 1'b0) begin
      bad++; $display("FAIL start_err_clear got=%b exp=0", bus.start_err);
    end
    load_range(10, 32, 0, 16'h0300);
    expect_rom_ready_rise();
    bus.start_in = 1'b1;
    #1;
    total++;
    if (bus.start_out !== 1'b1) begin
      bad++; $display("FAIL start_pass got=%b exp=1", bus.start_out);
    end
    tick();
    total++;
    if (bus.start_err !== 1'b0) begin
      bad++; $display("FAIL start_pass_err got=%b exp=0", bus.start_err);
    end
    bus.core_busy = 1'b1;
    #1;
    total++;
    if (bus.start_out !== 1'b0) begin
      bad++; $display("FAIL start_busy got=%b exp=0", bus.start_out);
    end
    tick();
    bus.start_in  = 1'b0;
    bus.core_busy = 1'b0;
    total++;
    if (bus.start_err !== 1'b1) begin
      bad++; $display("FAIL start_busy_err got=%b exp=1", bus.start_err);
    end
  endtask

  task automatic test_locked_port();
    bus.core_cen_n = 1'b0;
    bus.core_addr  = 5'h13;
    bus.valid_in   = 1'b1;
    bus.din        = 16'hDEAD;
    total++;
    if (bus.ready_out !== 1'b0) begin
      bad++; $display("FAIL locked_ready got=%b exp=0", bus.ready_out);
    end
    tick();
    total++;
    if ({bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr, bus.load_count} !==
        {1'b0, 1'b1, 5'h13, 6'd32}) begin
      bad++;
      $display("FAIL locked_port got cen=%b wen=%b addr=%h cnt=%0d exp cen=0 wen=1 addr=13 cnt=32",
               bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr, bus.load_count);
    end
    bus.core_cen_n = 1'b1;
    bus.core_addr  = 5'h07;
    tick();
    bus.valid_in = 1'b0;
    total++;
    if ({bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr} !== {1'b1, 1'b1, 5'h07}) begin
      bad++;
      $display("FAIL locked_follow got cen=%b wen=%b addr=%h exp cen=1 wen=1 addr=07",
               bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr);
    end
  endtask

  task automatic test_reload_busy();
    bus.core_busy = 1'b1;
    bus.reload    = 1'b1;
    tick();
    bus.reload = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({bus.rom_ready, bus.load_count} !== {1'b1, 6'd32}) begin
        bad++; $display("FAIL reload_held cyc=%0d got rr=%b cnt=%0d exp rr=1 cnt=32",
                        k, bus.rom_ready, bus.load_count);
      end
      tick();
    end
    bus.core_busy = 1'b0;
    tick();
    total++;
    if ({bus.rom_ready, bus.load_count, bus.ready_out} !== {1'b0, 6'd0, 1'b0}) begin
      bad++; $display("FAIL reload_pend_act got rr=%b cnt=%0d rdy=%b exp 0/0/0",
                      bus.rom_ready, bus.load_count, bus.ready_out);
    end
    tick();
    // Reload coinciding with a transfer: the word must be dropped.
    bus.valid_in = 1'b1;
    bus.din      = 16'hBEEF;
    bus.reload   = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.reload   = 1'b0;
    total++;
    if ({bus.ready_out, bus.load_count} !== {1'b0, 6'd0}) begin
      bad++; $display("FAIL drop_reload got rdy=%b cnt=%0d exp rdy=0 cnt=0",
                      bus.ready_out, bus.load_count);
    end
    tick();
    total++;
    if ({bus.mem_cen_n, bus.mem_wen_n, bus.ready_out} !== 3'b111) begin
      bad++; $display("FAIL drop_no_write got cen=%b wen=%b rdy=%b exp 1/1/1",
                      bus.mem_cen_n, bus.mem_wen_n, bus.ready_out);
    end
    load_range(0, 32, 0, 16'h0400);
    expect_rom_ready_rise();
  endtask

  task automatic test_reset_midload();
    do_reload();
    load_range(0, 7, 0, 16'h0500);
    reset = 1'b1;
    tick();
    total++;
    if ({bus.ready_out, bus.rom_ready, bus.load_count, bus.mem_cen_n, bus.mem_wen_n,
         bus.mem_addr, bus.mem_din, bus.start_err} !==
        {1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 5'd0, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL midload_reset got rdy=%b rr=%b cnt=%0d cen=%b wen=%b addr=%h din=%h err=%b",
               bus.ready_out, bus.rom_ready, bus.load_count, bus.mem_cen_n, bus.mem_wen_n,
               bus.mem_addr, bus.mem_din, bus.start_err);
    end
    reset = 1'b0;
    tick();
    load_range(0, 32, 0, 16'h0600);
    expect_rom_ready_rise();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    bus.din        = '0;
    bus.valid_in   = 1'b0;
    bus.reload     = 1'b0;
    bus.start_in   = 1'b0;
    bus.core_busy  = 1'b0;
    bus.core_cen_n = 1'b1;
    bus.core_addr  = '0;
    test_reset();
    test_full_load();
    test_gapped_load();
    test_start_gating();
    test_locked_port();
    test_reload_busy();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
